// File: rtl/bstr_tx_sequencer.sv
// Transmit sequencer: SYNC, PID, byte-streamed payload and optional CRC16 (BSTR_SEQ_CRC16_EN),
// serialised LSB first into the bit stuffer with stall and underflow handling.
module bstr_tx_sequencer #(
    parameter int LEN_W = 7
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             pkt_start,
    input  logic [3:0]       pkt_pid,
    input  logic [LEN_W-1:0] pkt_len,
    input  logic             pkt_crc,
    input  logic [7:0]       byte_data,
    input  logic             byte_valid,
    output logic             byte_ready,
    input  logic             stuff_hold,
    output logic             bstr_out,
    output logic             bstr_out_ready,
    output logic             stuff_en,
    output logic             eop,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_PID,
        S_DATA,
        S_CRC,
        S_EOP
    } state_t;

    // r_state names the bit to be emitted on the next edge; outputs show the one emitted last.
    state_t           r_state;
    logic [3:0]       r_bit_cnt;
    logic [7:0]       r_pid_byte;
    logic [LEN_W-1:0] r_bytes_left;
    logic [7:0]       r_shift;
    logic             r_shift_full;
    logic             r_bstr_out;
    logic             r_bstr_out_ready;
    logic             r_stuff_en;
    logic             r_eop;
    logic             r_busy;

    logic             w_hold;
    logic             w_bytes_remain;
    logic             w_take_byte;
    logic             w_bit_adv;
    logic             w_data_bit;
    state_t           w_post_payload;

    assign w_hold         = (r_state != S_IDLE) && stuff_hold;
    assign w_bytes_remain = (r_bytes_left != '0);
    assign byte_ready     = !stuff_hold && w_bytes_remain && (r_state == S_DATA) && !r_shift_full;
    assign w_take_byte    = byte_ready && byte_valid;
    assign w_bit_adv      = (r_state == S_DATA) && !stuff_hold && (r_shift_full || w_take_byte);
    assign w_data_bit     = r_shift_full ? r_shift[0] : byte_data[0];

`ifdef BSTR_SEQ_CRC16_EN
    logic        r_crc_req;
    logic [15:0] r_crc;
    logic        w_crc_bit;

    function automatic logic [15:0] f_crc_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[15];
        return {crc[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    endfunction

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_crc_req <= 1'b0;
            r_crc     <= 16'hFFFF;
        end else if (r_state == S_IDLE && pkt_start) begin
            r_crc_req <= pkt_crc;
            r_crc     <= 16'hFFFF;
        end else if (w_bit_adv) begin
            r_crc <= f_crc_step(r_crc, w_data_bit);
        end
    end

    assign w_post_payload = r_crc_req ? S_CRC : S_EOP;
    assign w_crc_bit      = ~r_crc[4'd15 - r_bit_cnt];
`else
    logic w_unused_crc;
    assign w_unused_crc   = pkt_crc;
    assign w_post_payload = S_EOP;
`endif

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state          <= S_IDLE;
            r_bit_cnt        <= '0;
            r_pid_byte       <= '0;
            r_bytes_left     <= '0;
            r_shift          <= '0;
            r_shift_full     <= 1'b0;
            r_bstr_out       <= 1'b0;
            r_bstr_out_ready <= 1'b0;
            r_stuff_en       <= 1'b0;
            r_eop            <= 1'b0;
            r_busy           <= 1'b0;
        end else if (!w_hold) begin
            case (r_state)
                S_IDLE: begin
                    r_bstr_out_ready <= 1'b0;
                    r_stuff_en       <= 1'b0;
                    r_eop            <= 1'b0;
                    r_busy           <= pkt_start;
                    if (pkt_start) begin
                        r_state      <= S_SYNC;
                        r_bit_cnt    <= '0;
                        r_pid_byte   <= {~pkt_pid, pkt_pid};
                        r_bytes_left <= pkt_len;
                        r_shift_full <= 1'b0;
                    end
                end
                S_SYNC: begin
                    r_bstr_out       <= (r_bit_cnt == 4'd7);
                    r_bstr_out_ready <= 1'b1;
                    r_stuff_en       <= 1'b0;
                    if (r_bit_cnt == 4'd7) begin
                        r_bit_cnt <= '0;
                        r_state   <= S_PID;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                    end
                end
                S_PID: begin
                    r_bstr_out       <= r_pid_byte[r_bit_cnt[2:0]];
                    r_bstr_out_ready <= 1'b1;
                    r_stuff_en       <= 1'b1;
                    if (r_bit_cnt == 4'd7) begin
                        r_bit_cnt <= '0;
                        r_state   <= w_bytes_remain ? S_DATA : w_post_payload;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                    end
                end
                S_DATA: begin
                    r_stuff_en       <= 1'b1;
                    r_bstr_out_ready <= w_bit_adv;
                    // A byte taken while the register is empty goes straight out as bit 0.
                    if (w_take_byte) begin
                        r_bstr_out   <= byte_data[0];
                        r_shift      <= {1'b0, byte_data[7:1]};
                        r_shift_full <= 1'b1;
                        r_bit_cnt    <= 4'd1;
                        r_bytes_left <= r_bytes_left - LEN_W'(1);
                    end else if (r_shift_full) begin
                        r_bstr_out <= r_shift[0];
                        r_shift    <= {1'b0, r_shift[7:1]};
                        if (r_bit_cnt == 4'd7) begin
                            r_shift_full <= 1'b0;
                            r_bit_cnt    <= '0;
                            if (!w_bytes_remain) begin
                                r_state <= w_post_payload;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end
                end
`ifdef BSTR_SEQ_CRC16_EN
                S_CRC: begin
                    r_bstr_out       <= w_crc_bit;
                    r_bstr_out_ready <= 1'b1;
                    r_stuff_en       <= 1'b1;
                    if (r_bit_cnt == 4'd15) begin
                        r_bit_cnt <= '0;
                        r_state   <= S_EOP;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                    end
                end
`endif
                S_EOP: begin
                    r_bstr_out_ready <= 1'b0;
                    r_stuff_en       <= 1'b0;
                    r_eop            <= 1'b1;
                    r_state          <= S_IDLE;
                end
                default: begin
                    r_bstr_out_ready <= 1'b0;
                    r_stuff_en       <= 1'b0;
                    r_eop            <= 1'b0;
                    r_busy           <= 1'b0;
                    r_state          <= S_IDLE;
                end
            endcase
        end
    end

    assign bstr_out       = r_bstr_out;
    assign bstr_out_ready = r_bstr_out_ready;
    assign stuff_en       = r_stuff_en;
    assign eop            = r_eop;
    assign busy           = r_busy;

endmodule
